ppe_grant_sched: RTL and testbench

- Downstream controller wrapped around the 512-wide pipelined programmable priority encoder (PPE).
- Accumulates pending request bits and drives the PPE Req vector and priority pointer (P_enc).
- Captures the PPE result, presents it as a grant with a valid/ready handshake, then clears the granted bit and advances the round-robin pointer.
- Keeps one PPE lookup in flight at a time, so no stale result is ever consumed.

---
 rtl/ppe_grant_sched.sv | 255 +++++++++++++++++++++++++
 tb/tb_ppe_grant_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_grant_sched.sv
// ---------------------------------------------------------------------------
// ppe_grant_sched
//
// Purpose:
//   Grant scheduler that sits downstream of the 512-wide pipelined
//   programmable priority encoder (PPE). The block works as follows:
//     - It accumulates pending request bits.
//     - It hands a frozen snapshot of those bits, plus a round-robin pointer,
//       to the PPE.
//     - It waits a fixed number of cycles for the PPE result.
//     - It presents the winner as a valid/ready grant.
//     - On acceptance it clears the granted bit and moves the pointer past
//       the winner.
//   Only one lookup is ever in flight, so a PPE result is always paired
//   with the request vector and pointer that produced it.
//
// Optional feature (compile-time macro PPE_GNT_CNT_EN):
//   When defined, the block adds a 32-bit free-running grant counter
//   (gnt_cnt) and a synchronous clear input (cnt_clr). When the macro is
//   undefined, neither port nor any counter logic exists.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   req_set      [N]  one-cycle set pulses, bit i marks requester i pending
//   ppe_req      [N]  PPE Req vector, frozen while a lookup is in flight
//   ppe_ptr      [IW] PPE P_enc, index where the priority search starts
//   ppe_valid    PPE valid (a grant was found)
//   ppe_value    [IW] PPE o_value = (granted index + 1) mod N
//   gnt_valid    grant available
//   gnt_ready    consumer accepts the grant
//   gnt_idx      [IW] granted requester index
//   pending_any  OR of the pending register
//   err_nogrant  sticky, set when the PPE found no winner for a non-empty Req
//   cnt_clr      (PPE_GNT_CNT_EN only) zero the grant counter
//   gnt_cnt      [32] (PPE_GNT_CNT_EN only) number of accepted grants
// ---------------------------------------------------------------------------
module ppe_grant_sched #(
  parameter int N         = 512,
  parameter int IW        = 9,
  parameter int VALID_LAT = 3,
  parameter int VALUE_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_set,
  output logic [N-1:0]  ppe_req,
  output logic [IW-1:0] ppe_ptr,
  input  logic          ppe_valid,
  input  logic [IW-1:0] ppe_value,
  output logic          gnt_valid,
  input  logic          gnt_ready,
  output logic [IW-1:0] gnt_idx,
  output logic          pending_any,
  output logic          err_nogrant
`ifdef PPE_GNT_CNT_EN
  ,
  input  logic          cnt_clr,
  output logic [31:0]   gnt_cnt
`endif
);

  // Wait counter is wide enough to reach VALUE_LAT with a spare bit.
  localparam int CW = $clog2(VALUE_LAT + 1) + 1;
  localparam logic [CW-1:0] VALID_CNT = CW'(VALID_LAT);
  localparam logic [CW-1:0] VALUE_CNT = CW'(VALUE_LAT);

  // When both latencies coincide, v_q would not be captured in time, so the
  // live ppe_valid is used on the value cycle instead.
  localparam bit SAME_LAT = (VALID_LAT == VALUE_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;

  logic [N-1:0]  pending_reg;
  logic [N-1:0]  pending_next;
  logic [N-1:0]  clr_mask;
  logic [N-1:0]  ppe_req_reg;
  logic [IW-1:0] ppe_ptr_reg;
  logic [IW-1:0] nxt_ptr_reg;
  logic [IW-1:0] gnt_idx_reg;
  logic [CW-1:0] cnt_reg;
  logic          v_q_reg;
  logic          err_reg;

  logic          handshake;
  logic          issue;
  logic          lookup_done;
  logic          valid_now;

  // -------------------------------------------------------------------------
  // Pending register. Clear first, then set, so a set pulse that lands on
  // the bit being granted in the same cycle keeps that bit pending.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign clr_mask[gi] = handshake && (gnt_idx_reg == IW'(gi));
    end
  endgenerate

  assign pending_next = (pending_reg & ~clr_mask) | req_set;
  assign pending_any  = |pending_reg;

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------
  assign lookup_done = (state_reg == ST_WAIT) && (cnt_reg == VALUE_CNT);
  assign valid_now   = SAME_LAT ? ppe_valid : v_q_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pending_any) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lookup_done) begin
          state_next = valid_now ? ST_GRANT : ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (gnt_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_valid = 1'b0;
    issue     = 1'b0;
    case (state_reg)
      ST_IDLE:  issue     = pending_any;
      ST_GRANT: gnt_valid = 1'b1;
      default: begin
        gnt_valid = 1'b0;
        issue     = 1'b0;
      end
    endcase
  end

  // gnt_ready is only meaningful while a grant is being offered.
  assign handshake = gnt_valid && gnt_ready;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
      ppe_req_reg <= '0;
      ppe_ptr_reg <= '0;
      nxt_ptr_reg <= '0;
      gnt_idx_reg <= '0;
      cnt_reg     <= '0;
      v_q_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;

      case (state_reg)
        ST_IDLE: begin
          // Snapshot the pending set. Bits arriving later wait for the next
          // lookup. The pointer is deliberately left untouched here.
          if (issue) begin
            ppe_req_reg <= pending_reg;
            cnt_reg     <= CW'(1);
            v_q_reg     <= 1'b0;
          end else begin
            ppe_req_reg <= '0;
          end
        end

        ST_WAIT: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == VALID_CNT) begin
            v_q_reg <= ppe_valid;
          end
          if (lookup_done) begin
            cnt_reg <= '0;
            if (valid_now) begin
              // The PPE reports winner+1, so subtracting one recovers the
              // winner. Value 0 therefore wraps to index N-1.
              gnt_idx_reg <= ppe_value - IW'(1);
              nxt_ptr_reg <= ppe_value;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end

        ST_GRANT: begin
          // Next search starts just past the winner (wrap comes for free
          // from the PPE's modulo value).
          if (gnt_ready) begin
            ppe_ptr_reg <= nxt_ptr_reg;
          end
        end

        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign ppe_req     = ppe_req_reg;
  assign ppe_ptr     = ppe_ptr_reg;
  assign gnt_idx     = gnt_idx_reg;
  assign err_nogrant = err_reg;

`ifdef PPE_GNT_CNT_EN
  // -------------------------------------------------------------------------
  // Grant counter. A clear takes precedence over a coincident handshake.
  // The increment wraps naturally at 2^32.
  // -------------------------------------------------------------------------
  logic [31:0] gnt_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_cnt_reg <= '0;
    end else if (cnt_clr) begin
      gnt_cnt_reg <= '0;
    end else if (handshake) begin
      gnt_cnt_reg <= gnt_cnt_reg + 32'd1;
    end
  end

  assign gnt_cnt = gnt_cnt_reg;
`endif

endmodule

// File: tb/tb_ppe_grant_sched.sv
// ---------------------------------------------------------------------------
// tb_ppe_grant_sched
//
// Directed bench for ppe_grant_sched. It contains two independent pieces:
//   - A latency-accurate PPE stand-in, which drives ppe_valid and ppe_value.
//   - A transaction-level scheduler model, which predicts every DUT output
//     each cycle.
// A single compare process checks the DUT against that model on every
// negative edge. Directed sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_ppe_grant_sched;

  localparam int N         = 512;
  localparam int IW        = 9;
  localparam int VALID_LAT = 3;
  localparam int VALUE_LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_set;
  logic [N-1:0]  ppe_req;
  logic [IW-1:0] ppe_ptr;
  logic          ppe_valid;
  logic [IW-1:0] ppe_value;
  logic          gnt_valid;
  logic          gnt_ready;
  logic [IW-1:0] gnt_idx;
  logic          pending_any;
  logic          err_nogrant;
`ifdef PPE_GNT_CNT_EN
  logic          cnt_clr;
  logic [31:0]   gnt_cnt;
`endif

  always #5 clk = ~clk;

  ppe_grant_sched #(
    .N(N), .IW(IW), .VALID_LAT(VALID_LAT), .VALUE_LAT(VALUE_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_set     (req_set),
    .ppe_req     (ppe_req),
    .ppe_ptr     (ppe_ptr),
    .ppe_valid   (ppe_valid),
    .ppe_value   (ppe_value),
    .gnt_valid   (gnt_valid),
    .gnt_ready   (gnt_ready),
    .gnt_idx     (gnt_idx),
    .pending_any (pending_any),
    .err_nogrant (err_nogrant)
`ifdef PPE_GNT_CNT_EN
    ,
    .cnt_clr     (cnt_clr),
    .gnt_cnt     (gnt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit check_en  = 1'b0;
  bit ppe_force = 1'b0;

  // Round-robin search: first set bit at or after 'start', wrapping around.
  // Returns -1 when the vector is empty.
  function automatic int first_from(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (v[j] === 1'b1) return j;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // PPE stand-in. Valid is observable 2 edges after the inputs change, so
  // it is ready when sampled on the 3rd edge after issue. The value is one
  // stage deeper. Early sampling sees the previous lookup's result.
  // -------------------------------------------------------------------------
  logic [2:0]    vp    = '0;
  logic [IW-1:0] valp0 = '0;
  logic [IW-1:0] valp1 = '0;
  logic [IW-1:0] valp2 = '0;
  int            ppe_w;

  always @(posedge clk) begin
    ppe_w = first_from(ppe_req, int'(ppe_ptr));
    vp    <= {vp[1:0], (ppe_w >= 0)};
    valp0 <= (ppe_w >= 0) ? IW'((ppe_w + 1) % N) : '0;
    valp1 <= valp0;
    valp2 <= valp1;
  end

  assign ppe_valid = vp[1] && !ppe_force;
  assign ppe_value = valp2;

  // -------------------------------------------------------------------------
  // Scheduler model: lookups as timed transactions (issue, then a result
  // VALUE_LAT edges later), with a grant that lives until accepted.
  // -------------------------------------------------------------------------
  logic [N-1:0] m_pending = '0;
  logic [N-1:0] m_req     = '0;
  int           m_ptr     = 0;
  int           m_idx     = 0;
  int           m_age     = 0;
  bit           m_gv      = 1'b0;
  bit           m_err     = 1'b0;
  bit           m_busy    = 1'b0;
  bit           m_fault   = 1'b0;
  int unsigned  m_cnt     = 0;

  always @(posedge clk) begin
    logic [N-1:0] clr;
    bit hs;
    if (!rst_n) begin
      m_pending = '0; m_req = '0; m_ptr = 0; m_idx = 0; m_age = 0;
      m_gv = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_fault = 1'b0; m_cnt = 0;
    end else begin
      hs  = m_gv && gnt_ready;
      clr = '0;
      if (hs) clr[m_idx] = 1'b1;
      if (m_gv) begin
        if (gnt_ready) begin
          m_gv  = 1'b0;
          m_ptr = (m_idx + 1) % N;
        end
      end else if (m_busy) begin
        m_age++;
        if (m_age == VALUE_LAT) begin
          m_busy = 1'b0;
          if (m_fault) m_err = 1'b1;
          else begin
            m_gv  = 1'b1;
            m_idx = first_from(m_req, m_ptr);
          end
        end
      end else if (m_pending != '0) begin
        m_req   = m_pending;
        m_busy  = 1'b1;
        m_age   = 0;
        m_fault = ppe_force;
      end else begin
        m_req = '0;
      end
      m_pending = (m_pending & ~clr) | req_set;
`ifdef PPE_GNT_CNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (hs) m_cnt = m_cnt + 1;
`endif
    end
  end

  // Single compare process against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("ppe_req",     ppe_req,             m_req);
      check("ppe_ptr",     N'(ppe_ptr),         N'(m_ptr));
      check("gnt_valid",   N'(gnt_valid),       N'(m_gv));
      check("gnt_idx",     N'(gnt_idx),         N'(m_idx));
      check("pending_any", N'(pending_any),     N'(m_pending != '0));
      check("err_nogrant", N'(err_nogrant),     N'(m_err));
`ifdef PPE_GNT_CNT_EN
      check("gnt_cnt",     N'(gnt_cnt),         N'(m_cnt));
`endif
      if (gnt_valid && gnt_ready)
        $display("GNT idx=%0d ptr=%0d t=%0t", gnt_idx, ppe_ptr, $time);
    end
  end

  // -------------------------------------------------------------------------
  // Directed stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int b);
    req_set    = '0;
    req_set[b] = 1'b1;
    tick();
    req_set    = '0;
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    while (!gnt_valid && n < 40) begin
      tick();
      n++;
    end
    check(name, N'(gnt_valid), N'(1));
  endtask

  task automatic accept();
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
  endtask

  task automatic grant_one(input int b, input string name);
    pulse(b);
    wait_gnt({name, "_wait"});
    check({name, "_idx"}, N'(gnt_idx), N'(b));
    accept();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    logic [N-1:0] snap;
    int exp_idx [3];
    int exp_ptr [3];
    exp_idx = '{400, 3, 100};
    exp_ptr = '{401, 4, 101};

    rst_n     = 1'b0;
    req_set   = '0;
    gnt_ready = 1'b0;
`ifdef PPE_GNT_CNT_EN
    cnt_clr   = 1'b0;
`endif
    repeat (3) tick();
    check_en = 1'b1;
    check("rst_gnt_valid", N'(gnt_valid), N'(0));
    check("rst_ppe_ptr",   N'(ppe_ptr),   N'(0));
    check("rst_ppe_req",   ppe_req,       '0);
    check("rst_err",       N'(err_nogrant), N'(0));
    rst_n = 1'b1;
    tick();

    // 1: single request, latency and pointer update
    req_set    = '0;
    req_set[5] = 1'b1;
    n = 0;
    do begin
      tick();
      req_set = '0;
      n++;
    end while (!gnt_valid && n < 40);
    check("t1_latency", N'(n), N'(6));
    check("t1_idx", N'(gnt_idx), N'(5));
    accept();
    check("t1_ptr", N'(ppe_ptr), N'(6));
    check("t1_pending_any", N'(pending_any), N'(0));
    check("t1_gv_low", N'(gnt_valid), N'(0));

    // 2: three pending requests with the pointer at 101, ready tied high
    grant_one(100, "t2_pre");
    check("t2_ptr101", N'(ppe_ptr), N'(101));
    gnt_ready = 1'b1;
    req_set = '0;
    req_set[3] = 1'b1; req_set[100] = 1'b1; req_set[400] = 1'b1;
    tick();
    req_set = '0;
    for (int g = 0; g < 3; g++) begin
      wait_gnt("t2_wait");
      check("t2_idx", N'(gnt_idx), N'(exp_idx[g]));
      tick();
      check("t2_ptr", N'(ppe_ptr), N'(exp_ptr[g]));
    end
    gnt_ready = 1'b0;

    // 3: top index, PPE value 0, pointer wraps to 0
    grant_one(511, "t3");
    check("t3_ptr", N'(ppe_ptr), N'(0));

    // 4: set and clear of bit 7 in the same cycle, set wins
    pulse(7);
    wait_gnt("t4_wait1");
    check("t4_idx1", N'(gnt_idx), N'(7));
    gnt_ready  = 1'b1;
    req_set[7] = 1'b1;
    tick();
    gnt_ready = 1'b0;
    req_set   = '0;
    check("t4_still_pending", N'(pending_any), N'(1));
    wait_gnt("t4_wait2");
    check("t4_idx2", N'(gnt_idx), N'(7));
    accept();

    // 5: back-pressure for 20 cycles, then reset mid-grant
    pulse(42);
    wait_gnt("t5_wait");
    snap = '0;
    snap[42] = 1'b1;
    repeat (20) tick();
    check("t5_gv_held", N'(gnt_valid), N'(1));
    check("t5_idx_held", N'(gnt_idx), N'(42));
    check("t5_req_held", ppe_req, snap);
    check("t5_ptr_held", N'(ppe_ptr), N'(8));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rst_gv", N'(gnt_valid), N'(0));
    check("t5_rst_idx", N'(gnt_idx), N'(0));
    check("t5_rst_req", ppe_req, '0);
    check("t5_rst_ptr", N'(ppe_ptr), N'(0));
    check("t5_rst_pend", N'(pending_any), N'(0));

    // 6: PPE never reports valid, so err_nogrant goes sticky
    ppe_force = 1'b1;
    pulse(9);
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (gnt_valid) saw = 1'b1;
    end
    check("t6_err", N'(err_nogrant), N'(1));
    check("t6_no_gv", N'(saw), N'(0));
    check("t6_pend", N'(pending_any), N'(1));
    rst_n     = 1'b0;
    ppe_force = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_err_rst", N'(err_nogrant), N'(0));
    tick();

`ifdef PPE_GNT_CNT_EN
    // 7: grant counter, clear, and clear coinciding with a handshake
    grant_one(1, "t7a");
    grant_one(2, "t7b");
    grant_one(3, "t7c");
    check("t7_cnt3", N'(gnt_cnt), N'(3));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t7_cnt_clr", N'(gnt_cnt), N'(0));
    pulse(4);
    wait_gnt("t7_wait");
    gnt_ready = 1'b1;
    cnt_clr   = 1'b1;
    tick();
    gnt_ready = 1'b0;
    cnt_clr   = 1'b0;
    check("t7_cnt_clr_hs", N'(gnt_cnt), N'(0));
`endif

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
